// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that pushes whole messages from several requesters into a UART TX FIFO
module uart_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] msg_len,
    input  logic [NUM_REQ*8-1:0]     msg_data,
    input  logic                     tx_full,
    output logic                     tx_push,
    output logic [7:0]               tx_push_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LEN_W-1:0]         byte_idx,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    ptr, win, sel, idx;
    logic [LEN_W-1:0] len;
    logic             found;
    logic [7:0]       data_a [NUM_REQ];
    logic [LEN_W-1:0] len_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign data_a[g] = msg_data[g*8 +: 8];
        assign len_a[g]  = msg_len[g*LEN_W +: LEN_W];
    end

    assign tx_push      = (state == SEND) && !tx_full;
    assign tx_push_data = data_a[sel];
    assign busy         = state != IDLE;

    // round-robin search starting at the priority pointer; first set req wins
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // message FSM: latch winner and length, stream bytes under backpressure, pulse done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            done     <= '0;
            byte_idx <= '0;
            len      <= '0;
            ptr      <= '0;
            sel      <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (found) begin
                    state    <= SEND;
                    sel      <= win;
                    grant    <= NUM_REQ'(1) << win;
                    len      <= len_a[win];
                    byte_idx <= '0;
                end
                SEND: if (!tx_full) begin
                    if (byte_idx == len) begin
                        state <= DONE;
                        done  <= grant;
                        ptr   <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst, tx_full, tx_push, busy;
    logic [N-1:0]    req, grant, done;
    logic [N*LW-1:0] msg_len;
    logic [N*8-1:0]  msg_data;
    logic [7:0]      tx_push_data;
    logic [LW-1:0]   byte_idx;

    int n_tests = 0;
    int n_fail  = 0;

    bit              rst_q    = 1'b0;
    bit              active   = 1'b0;
    bit              was_idle = 1'b1;
    logic [N-1:0]    req_q    = '0;
    logic [N*LW-1:0] len_q    = '0;
    int ptr = 0, m_win = 0, m_len = 0, m_cnt = 0;
    int total_done = 0, last_idx = 0, last_bytes = 0, last_win = 0;
    int gq[$];
    int bq[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .msg_len(msg_len), .msg_data(msg_data),
        .tx_full(tx_full), .tx_push(tx_push), .tx_push_data(tx_push_data),
        .grant(grant), .byte_idx(byte_idx), .done(done), .busy(busy)
    );

    function automatic logic [7:0] pat(int i, int k);
        return 8'((i + 1) * 16 + k);
    endfunction

    function automatic int rr(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // requesters serve their bytes from byte_idx
    always_comb begin
        msg_data = '0;
        for (int i = 0; i < N; i++) msg_data[i*8 +: 8] = pat(i, int'(byte_idx));
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // message-level reference model, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rst_q) begin
            check("rst_grant", 32'(grant), 0);
            check("rst_push", 32'(tx_push), 0);
            check("rst_done", 32'(done), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_idx", 32'(byte_idx), 0);
            active   = 1'b0;
            ptr      = 0;
            was_idle = 1'b1;
        end else if (!active && !(was_idle && req_q != 0)) begin
            check("idle_grant", 32'(grant), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_push", 32'(tx_push), 0);
            check("idle_done", 32'(done), 0);
            was_idle = 1'b1;
        end else begin
            if (!active) begin
                m_win    = rr(req_q, ptr);
                m_len    = int'(len_q[m_win*LW +: LW]);
                m_cnt    = 0;
                active   = 1'b1;
                was_idle = 1'b0;
                last_win = m_win;
                gq.push_back(m_win);
            end
            check("grant", 32'(grant), 32'(1 << m_win));
            check("busy", 32'(busy), 1);
            if (m_cnt <= m_len) begin
                check("push", 32'(tx_push), 32'(!tx_full));
                check("idx", 32'(byte_idx), 32'(m_cnt));
                check("no_early_done", 32'(done), 0);
                if (!tx_full) begin
                    check("data", 32'(tx_push_data), 32'(pat(m_win, m_cnt)));
                    m_cnt++;
                end
            end else begin
                check("done", 32'(done), 32'(1 << m_win));
                check("done_push", 32'(tx_push), 0);
                last_idx   = int'(byte_idx);
                last_bytes = m_cnt;
                bq.push_back(m_cnt);
                active     = 1'b0;
                ptr        = (m_win + 1) % N;
                total_done++;
            end
        end
        rst_q = rst;
        req_q = req;
        len_q = msg_len;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(int n, int budget);
        int tgt = total_done + n;
        int c = 0;
        while (total_done < tgt && c < budget) begin
            tick();
            c++;
        end
        check("wait_done_timeout", 32'(total_done >= tgt), 1);
    endtask

    task automatic wait_idx(int k);
        int c = 0;
        while (!(busy && grant != 0 && done == 0 && int'(byte_idx) == k) && c < 100) begin
            tick();
            c++;
        end
        check("wait_idx_timeout", 32'(c < 100), 1);
    endtask

    task automatic idle_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int d0;
        int rr_exp[4] = '{0, 1, 2, 0};
        int at_win[2] = '{0, 1};
        int at_len[2] = '{3, 2};
        rst = 1'b0;
        req = '0;
        msg_len = '0;
        tx_full = 1'b0;
        tick(3);
        check("reset_grant", 32'(grant), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        msg_len = 12'h002;
        req = 3'b001;
        tick(4);
        check("single_busy_in_done", 32'(busy), 1);
        req = '0;
        tick();
        check("single_busy_low", 32'(busy), 0);
        check("single_bytes", 32'(last_bytes), 3);
        msg_len = 12'h003;
        req = 3'b001;
        wait_idx(1);
        tx_full = 1'b1;
        tick(3);
        tx_full = 1'b0;
        wait_done(1, 50);
        req = '0;
        check("bp_bytes", 32'(last_bytes), 4);
        msg_len = 12'h00F;
        req = 3'b001;
        wait_done(1, 60);
        req = '0;
        check("bound_bytes", 32'(last_bytes), 16);
        check("bound_idx", 32'(last_idx), 15);
        idle_reset();
        gq.delete();
        bq.delete();
        msg_len = '0;
        req = 3'b111;
        wait_done(4, 60);
        req = '0;
        check("rr_count", 32'(gq.size()), 4);
        for (int k = 0; k < 4; k++)
            if (gq.size() > k && bq.size() > k) begin
                check("rr_seq", 32'(gq[k]), 32'(rr_exp[k]));
                check("rr_bytes", 32'(bq[k]), 1);
            end
        idle_reset();
        gq.delete();
        bq.delete();
        msg_len = {4'h0, 4'h1, 4'h2};
        req = 3'b011;
        wait_idx(1);
        req = 3'b010;
        msg_len[3:0] = 4'h7;
        wait_done(2, 60);
        req = '0;
        check("atom_count", 32'(gq.size()), 2);
        for (int k = 0; k < 2; k++)
            if (gq.size() > k && bq.size() > k) begin
                check("atom_seq", 32'(gq[k]), 32'(at_win[k]));
                check("atom_bytes", 32'(bq[k]), 32'(at_len[k]));
            end
        msg_len = 12'h004;
        req = 3'b001;
        wait_idx(2);
        rst = 1'b0;
        req = '0;
        tick();
        rst = 1'b1;
        check("abort_grant", 32'(grant), 0);
        check("abort_push", 32'(tx_push), 0);
        check("abort_done", 32'(done), 0);
        req = 3'b010;
        wait_done(1, 30);
        req = '0;
        check("abort_next_win", 32'(last_win), 1);
        d0 = total_done;
        repeat (3000) begin
            rst = $urandom_range(0, 499) != 0;
            tx_full = $urandom_range(0, 9) < 3;
            for (int i = 0; i < N; i++) begin
                msg_len[i*LW +: LW] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 3));
                if (done[i]) req[i] = $urandom_range(0, 1) == 1;
                else if (!req[i]) req[i] = $urandom_range(0, 3) == 0;
                else if (grant[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
            end
            tick();
        end
        rst = 1'b1;
        req = '0;
        tx_full = 1'b0;
        tick(40);
        check("rand_msgs", 32'((total_done - d0) > 100), 1);
        check("final_idle", 32'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
